// File: rtl/sram_arbiter_if.sv
// Request, response and SRAM pin bundle for sram_arbiter.
// slave: arbiter side; master: requesters plus the SRAM model/buffer.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 17
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_rdata;
  logic              vid_ack;

  logic [ADDR_W-1:0] sram_a;
  logic              sram_n_cs1;
  logic              sram_cs2;
  logic              sram_n_oe;
  logic              sram_n_we;
  logic [7:0]        sram_io_o;
  logic              sram_io_oe;
  logic [7:0]        sram_io_i;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  vid_req, vid_addr,
    output vid_rdata, vid_ack,
    output sram_a, sram_n_cs1, sram_cs2, sram_n_oe, sram_n_we, sram_io_o, sram_io_oe,
    input  sram_io_i,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output vid_req, vid_addr,
    input  vid_rdata, vid_ack,
    input  sram_a, sram_n_cs1, sram_cs2, sram_n_oe, sram_n_we, sram_io_o, sram_io_oe,
    output sram_io_i,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (CPU read/write, VID read-only) sequencer for one async 8-bit SRAM.
// Define SRAM_ARB_STARVE_GUARD_EN to let a starved CPU past a continuous VID stream.
module sram_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StAck
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              owner_vid_q, owner_vid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              force_cpu;
  logic              grant_vid;
  logic              grant_cpu;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign force_cpu = (starve_q == StarveMax) && bus.cpu_req && bus.vid_req;

  // Counts VID wins that left the CPU waiting; any CPU win clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (grant_cpu) begin
        starve_d = '0;
      end else if (grant_vid && bus.cpu_req && (starve_q != StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_cpu = 1'b0;
`endif

  assign grant_vid = bus.vid_req && !force_cpu;
  assign grant_cpu = bus.cpu_req && !grant_vid;

  always_comb begin
    state_d     = state_q;
    owner_vid_d = owner_vid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vid) begin
          owner_vid_d = 1'b1;
          addr_d      = bus.vid_addr;
          cnt_d       = WaitLoad;
          state_d     = StRd;
        end else if (grant_cpu) begin
          owner_vid_d = 1'b0;
          addr_d      = bus.cpu_addr;
          wdata_d     = bus.cpu_wdata;
          cnt_d       = WaitLoad;
          state_d     = bus.cpu_we ? StWrSetup : StRd;
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) begin
          if (owner_vid_q) begin
            vid_rdata_d = bus.sram_io_i;
          end else begin
            cpu_rdata_d = bus.sram_io_i;
          end
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrHold: state_d = StIdle;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_vid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_vid_q <= owner_vid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  // Pins decode straight from state flops so async reset releases them at once.
  logic wr_phase;
  logic cs_active;

  assign wr_phase  = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);
  assign cs_active = wr_phase || (state_q == StRd);

  assign bus.sram_a     = addr_q;
  assign bus.sram_io_o  = wdata_q;
  assign bus.sram_io_oe = wr_phase;
  assign bus.sram_n_cs1 = !cs_active;
  assign bus.sram_cs2   = cs_active;
  assign bus.sram_n_oe  = (state_q != StRd);
  assign bus.sram_n_we  = (state_q != StWrPulse);

  assign bus.cpu_ack   = ((state_q == StAck) && !owner_vid_q) || (state_q == StWrHold);
  assign bus.vid_ack   = (state_q == StAck) && owner_vid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: SRAM model, rdata scoreboards, strobe timing and
// grant order; expectations follow SRAM_ARB_STARVE_GUARD_EN when it is defined.
module tb_sram_arbiter;
  localparam int unsigned AW = 17;
  localparam int unsigned W  = 2;
  localparam int unsigned SL = 4;
  localparam logic [7:0] OrdC = 8'h43;
  localparam logic [7:0] OrdV = 8'h56;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) sif ();

  sram_arbiter #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (W),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sif)
  );

  // Async SRAM model: write while WE low with the driver enabled, read while OE low.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sif.sram_n_cs1 && sif.sram_cs2 && !sif.sram_n_we && sif.sram_io_oe)
      mem[sif.sram_a] <= sif.sram_io_o;
  end
  always_comb begin
    sif.sram_io_i = 8'h00;
    if (!sif.sram_n_cs1 && sif.sram_cs2 && !sif.sram_n_oe) sif.sram_io_i = mem[sif.sram_a];
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] cpu_sb[$];   // bit 8 set: read, check rdata
  logic [7:0] vid_sb[$];
  logic [7:0] order_q[$];

  int cyc, we_lo, ioe_hi, oe_first, oe_last, ack_cyc, cpu_acks, vid_acks;
  bit a_bad;
  logic [AW-1:0] a_exp;
  bit vid_stream;
  logic [7:0] vid_stream_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle at the falling edge, then apply requester drops after the rising edge.
  task automatic tick();
    bit cdrop, vdrop;
    logic [8:0] ce;
    cdrop = 1'b0;
    vdrop = 1'b0;
    @(negedge clk);
    cyc++;
    if (!sif.sram_n_we) we_lo++;
    if (sif.sram_io_oe) ioe_hi++;
    if (!sif.sram_n_oe) begin
      if (oe_first == 0) oe_first = cyc;
      oe_last = cyc;
    end
    if (sif.busy && (sif.sram_a !== a_exp)) a_bad = 1'b1;
    if (sif.cpu_ack) begin
      cpu_acks++;
      ack_cyc = cyc;
      order_q.push_back(OrdC);
      chk("cpu_ack_expected", 32'(cpu_sb.size() > 0), 32'd1);
      if (cpu_sb.size() > 0) begin
        ce = cpu_sb.pop_front();
        if (ce[8]) chk("cpu_rdata", {24'd0, sif.cpu_rdata}, {24'd0, ce[7:0]});
      end
      cdrop = 1'b1;
    end
    if (sif.vid_ack) begin
      vid_acks++;
      ack_cyc = cyc;
      order_q.push_back(OrdV);
      chk("vid_ack_expected", 32'(vid_sb.size() > 0), 32'd1);
      if (vid_sb.size() > 0) chk("vid_rdata", {24'd0, sif.vid_rdata}, {24'd0, vid_sb.pop_front()});
      if (vid_stream) vid_sb.push_back(vid_stream_val);
      vdrop = !vid_stream;
    end
    @(posedge clk);
    #1;
    if (cdrop) sif.cpu_req = 1'b0;
    if (vdrop) sif.vid_req = 1'b0;
  endtask

  task automatic clear_stats(input logic [AW-1:0] a);
    cyc = 0; we_lo = 0; ioe_hi = 0; oe_first = 0; oe_last = 0; ack_cyc = 0;
    a_bad = 1'b0; a_exp = a;
  endtask

  task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input string tag);
    int n0;
    @(negedge clk);
    sif.cpu_req = 1'b1; sif.cpu_we = we; sif.cpu_addr = a; sif.cpu_wdata = d;
    cpu_sb.push_back(we ? 9'h000 : {1'b1, exp_rd});
    clear_stats(a);
    n0 = cpu_acks;
    @(posedge clk);
    #1;
    // Post-grant input changes must not leak into the transaction.
    sif.cpu_addr = ~a; sif.cpu_wdata = ~d; sif.cpu_we = ~we;
    for (int i = 0; i < 20 && cpu_acks == n0; i++) tick();
    chk({tag, "_done"}, 32'(cpu_acks - n0), 32'd1);
    if (we) begin
      chk({tag, "_we_low_cycles"}, 32'(we_lo), 32'(W));
      chk({tag, "_io_oe_cycles"}, 32'(ioe_hi), 32'(W + 2));
      chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(W + 2));
      chk({tag, "_mem"}, {24'd0, mem[a]}, {24'd0, d});
    end else begin
      chk({tag, "_oe_first"}, 32'(oe_first), 32'd1);
      chk({tag, "_oe_last"}, 32'(oe_last), 32'(W));
      chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(W + 1));
      chk({tag, "_io_oe_cycles"}, 32'(ioe_hi), 32'd0);
    end
    chk({tag, "_addr_stable"}, {31'd0, a_bad}, 32'd0);
  endtask

  initial begin
    int n0, ncpu;
    logic [7:0] e;
    sif.cpu_req = 1'b0; sif.cpu_we = 1'b0; sif.cpu_addr = '0; sif.cpu_wdata = '0;
    sif.vid_req = 1'b0; sif.vid_addr = '0;
    vid_stream = 1'b0; vid_stream_val = '0;
    cpu_acks = 0; vid_acks = 0;
    clear_stats('0);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_n_cs1", {31'd0, sif.sram_n_cs1}, 32'd1);
    chk("rst_cs2", {31'd0, sif.sram_cs2}, 32'd0);
    chk("rst_n_oe", {31'd0, sif.sram_n_oe}, 32'd1);
    chk("rst_n_we", {31'd0, sif.sram_n_we}, 32'd1);
    chk("rst_io_oe", {31'd0, sif.sram_io_oe}, 32'd0);
    chk("rst_sram_a", 32'(sif.sram_a), 32'd0);
    chk("rst_io_o", {24'd0, sif.sram_io_o}, 32'd0);
    chk("rst_acks", {30'd0, sif.cpu_ack, sif.vid_ack}, 32'd0);
    chk("rst_rdata", {16'd0, sif.cpu_rdata, sif.vid_rdata}, 32'd0);
    chk("rst_busy", {31'd0, sif.busy}, 32'd0);
    reset_n = 1'b1;

    // Async reset in the middle of a read.
    @(negedge clk);
    sif.vid_req = 1'b1; sif.vid_addr = 17'h00300;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrd_oe_active", {31'd0, sif.sram_n_oe}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrd_strobes", {28'd0, sif.sram_n_cs1, sif.sram_cs2, sif.sram_n_oe, sif.sram_n_we},
        32'b1011);
    chk("midrd_io_oe", {31'd0, sif.sram_io_oe}, 32'd0);
    chk("midrd_acks", {30'd0, sif.cpu_ack, sif.vid_ack}, 32'd0);
    chk("midrd_busy", {31'd0, sif.busy}, 32'd0);
    sif.vid_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // CPU writes and a CPU read-back.
    cpu_txn(1'b1, 17'h1ABCD, 8'h5A, 8'h00, "wr_1abcd");
    cpu_txn(1'b1, 17'h00100, 8'h11, 8'h00, "wr_100");
    cpu_txn(1'b1, 17'h00200, 8'h22, 8'h00, "wr_200");
    cpu_txn(1'b0, 17'h1ABCD, 8'h00, 8'h5A, "rd_1abcd");

    // Simultaneous requests: VID first, CPU at the next idle.
    order_q.delete();
    @(negedge clk);
    sif.vid_req = 1'b1; sif.vid_addr = 17'h00200; vid_sb.push_back(8'h22);
    sif.cpu_req = 1'b1; sif.cpu_we = 1'b0; sif.cpu_addr = 17'h00100;
    cpu_sb.push_back({1'b1, 8'h11});
    n0 = cpu_acks;
    @(posedge clk);
    #1;
    for (int i = 0; i < 30 && cpu_acks == n0; i++) tick();
    chk("simul_done", 32'(cpu_acks - n0), 32'd1);
    chk("simul_count", 32'(order_q.size()), 32'd2);
    if (order_q.size() == 2) begin
      chk("simul_first", {24'd0, order_q[0]}, {24'd0, OrdV});
      chk("simul_second", {24'd0, order_q[1]}, {24'd0, OrdC});
    end

    // Continuous VID stream with the CPU pending.
    order_q.delete();
    vid_stream = 1'b1; vid_stream_val = 8'h11;
    @(negedge clk);
    sif.vid_req = 1'b1; sif.vid_addr = 17'h00100; vid_sb.push_back(8'h11);
    sif.cpu_req = 1'b1; sif.cpu_we = 1'b0; sif.cpu_addr = 17'h00200;
    cpu_sb.push_back({1'b1, 8'h22});
    @(posedge clk);
    #1;
    for (int i = 0; i < 100 && order_q.size() < 8; i++) tick();
    chk("stream_done", 32'(order_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < order_q.size(); i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
      e = (i == int'(SL)) ? OrdC : OrdV;
`else
      e = OrdV;
`endif
      chk($sformatf("stream_order%0d", i), {24'd0, order_q[i]}, {24'd0, e});
    end
    vid_stream = 1'b0;
    for (int i = 0; i < 60 && (sif.vid_req || sif.cpu_req || sif.busy); i++) tick();
    chk("drain_done", {29'd0, sif.vid_req, sif.cpu_req, sif.busy}, 32'd0);
    chk("sb_empty", 32'(cpu_sb.size() + vid_sb.size()), 32'd0);
    ncpu = 0;
    foreach (order_q[i]) if (order_q[i] == OrdC) ncpu++;
    chk("stream_cpu_grants", 32'(ncpu), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the board's single asynchronous 8-bit SRAM (17-bit address, separate chip-select, output-enable and write-enable strobes) between two requesters. The requesters are the MCU memory bus (CPU port) and the video scan-out fetcher (VID port). The block runs a multi-cycle read/write sequencer with programmable strobe width. It owns all SRAM control pins, and the board top instantiates the bidirectional `sram_io` buffer.

## Interface
**Parameters**
- `ADDR_W`, 17: SRAM address width.
- `WAIT_CYCLES`, 2: cycles the OE or WE strobe is held low. Legal range 1..15.
- `STARVE_LIMIT`, 4: number of consecutive VID grants while CPU is waiting before the CPU is forced in. Legal range 1..15.

**Ports** (reset `reset_n`, asynchronous, active-low; clock `clk`)
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `cpu_req` in 1: CPU access request, level.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data.
- `cpu_ack` out 1: one-cycle completion pulse for the CPU port.
- `vid_req` in 1: video read request, level. The VID port is read-only.
- `vid_addr` in ADDR_W: video address.
- `vid_rdata` out 8: video read data.
- `vid_ack` out 1: one-cycle completion pulse for the VID port.
- `sram_a` out ADDR_W: SRAM address.
- `sram_n_cs1` out 1: SRAM chip select 1, active-low.
- `sram_cs2` out 1: SRAM chip select 2, active-high.
- `sram_n_oe` out 1: SRAM output enable, active-low.
- `sram_n_we` out 1: SRAM write enable, active-low.
- `sram_io_o` out 8: data to drive onto the SRAM bus.
- `sram_io_oe` out 1: 1 = drive `sram_io_o` onto `sram_io`.
- `sram_io_i` in 8: data sampled from the SRAM bus.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- **Reset values:**
  - Reset forces IDLE.
  - `sram_n_cs1`=1, `sram_cs2`=0, `sram_n_oe`=1, `sram_n_we`=1, `sram_io_oe`=0.
  - `sram_a`=0, `sram_io_o`=0.
  - Both acks = 0, both rdata = 0x00, `busy`=0, starvation counter = 0.
- **Grant and latching:**
  - A grant happens only in IDLE.
  - On the grant edge the block latches the owner, address, write data and direction.
  - Requester inputs that change after the grant edge are ignored.
- **Arbitration:**
  - VID has fixed priority when both ports request in the same IDLE cycle.
  - The starvation guard can override this (see Configuration).
- **Read:**
  - IDLE → RD, held WAIT_CYCLES cycles, with CS active and `sram_n_oe`=0.
  - `sram_io_i` is captured into the owner's rdata on the final RD edge.
  - Then ACK: strobes inactive, owner's ack=1 for one cycle, then IDLE.
- **Write (CPU only):**
  - WR_SETUP, 1 cycle: CS active, address and data driven, `sram_io_oe`=1, WE high.
  - WR_PULSE, WAIT_CYCLES cycles: `sram_n_we`=0.
  - WR_HOLD, 1 cycle: WE high, data still driven, `cpu_ack`=1.
  - Then IDLE. `sram_io_oe` drops on entry to IDLE.
- **Data bus rule:** `sram_io_oe` is 1 only in WR_* states, so OE and the data driver are never active together.
- **Request handshake:**
  - A requester keeps req high through its ack cycle and drops it on the edge where it samples ack.
  - A req that is still high in IDLE is treated as a new transaction.
- **rdata holding:** each rdata holds its value until that port's next read completes.
- **Wait counter:** 4 bits, loaded with WAIT_CYCLES−1, counts down to 0.

## Timing
- The request is sampled at edge 0 (in IDLE).
- **Read, W = WAIT_CYCLES:**
  - RD during cycles 1..W.
  - ack and valid rdata in cycle W+1.
  - Next grant possible at edge W+2.
  - W=2 gives a 4-cycle turnaround.
- **Write:**
  - WR_SETUP in cycle 1.
  - WR_PULSE in cycles 2..W+1.
  - ack in cycle W+2.
  - W=2 gives a 5-cycle turnaround.
- `sram_a` is stable from the first strobe cycle through the cycle after the strobe deasserts.
- A request arriving while busy waits; no request is ever lost while req is held.
- Async reset mid-transaction:
  - strobes deassert immediately, and no ack is issued;
  - the requester re-issues after reset.

## Configuration
- **`SRAM_ARB_STARVE_GUARD_EN` defined:**
  - A counter increments on each VID grant taken while `cpu_req`=1, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and both ports request, the CPU is granted.
  - Any CPU grant clears the counter.
- **Undefined:** strict VID priority; no counter logic is synthesized.

## Test plan
- **Reset:** reset_n=0 mid-RD → all strobes inactive the same cycle, `sram_io_oe`=0, acks=0, `busy`=0.
- **CPU write:** CPU write addr 0x1ABCD, data 0x5A, W=2 → `sram_n_we` low for exactly 2 cycles, `sram_io_oe`=1 for 4 cycles, `cpu_ack` in cycle 4. A SRAM model then holds 0x5A at 0x1ABCD.
- **CPU read:** CPU read 0x1ABCD, SRAM model returns 0x5A → `sram_n_oe` low cycles 1–2, `cpu_ack` and `cpu_rdata`=0x5A in cycle 3; `sram_io_oe` stays 0 throughout.
- **Simultaneous requests:** `vid_req` and `cpu_req` rise in the same cycle → VID served first; CPU granted at the next IDLE and its `cpu_ack` follows.
- **Guard enabled:** `SRAM_ARB_STARVE_GUARD_EN` defined, STARVE_LIMIT=4, `vid_req` held continuously, CPU pending → grant order V,V,V,V,C,V….
- **Guard disabled:** macro undefined with the same stimulus → the CPU is never granted while `vid_req` stays high.
